// File: rtl/restador_serial.sv
// rtl/restador_serial.sv - bit-serial ripple-borrow subtractor, LSB first, start/busy/done handshake
module restador_celda #(
   parameter int PwrC = 0
) (
   input  logic x,
   input  logic y,
   input  logic q,
   output logic diff,
   output logic nq
);
   localparam int unused_pwrc = PwrC;

   assign diff = x ^ y ^ q;
   assign nq   = (~x & y) | (~(x ^ y) & q);
endmodule

module restador_serial #(
   parameter int WIDTH = 8,
   parameter int PwrC  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic [WIDTH-1:0] d,
   output logic             bo,
   output logic             busy,
   output logic             done
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh, b_sh, r_sh;
   logic             borrow;
   logic [CW-1:0]    cnt;
   logic             diff, nq;

   restador_celda #(.PwrC(PwrC)) u_celda (
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .q    (borrow),
      .diff (diff),
      .nq   (nq)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         r_sh   <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         d      <= '0;
         bo     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  borrow <= bi;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
               r_sh   <= {diff, r_sh[WIDTH-1:1]};
               borrow <= nq;
               // Counter is not advanced on the final edge so it never wraps in SHIFT.
               if (cnt == LAST) begin
                  d     <= {diff, r_sh[WIDTH-1:1]};
                  bo    <= nq;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_restador_serial.sv
// tb/tb_restador_serial.sv - directed and random checks of restador_serial at WIDTH 8, 16 and 2
module tb_restador_serial;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0, b = '0, d;
   logic       bi = 1'b0, bo, busy, done;

   logic        start16 = 1'b0, bi16 = 1'b0, bo16, busy16, done16;
   logic [15:0] a16 = '0, b16 = '0, d16;
   logic        start2 = 1'b0, bi2 = 1'b0, bo2, busy2, done2;
   logic [1:0]  a2 = '0, b2 = '0, d2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   restador_serial #(.WIDTH(8), .PwrC(0)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .bi(bi),
      .d(d), .bo(bo), .busy(busy), .done(done)
   );
   restador_serial #(.WIDTH(16), .PwrC(1)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16), .bi(bi16),
      .d(d16), .bo(bo16), .busy(busy16), .done(done16)
   );
   restador_serial #(.WIDTH(2), .PwrC(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .bi(bi2),
      .d(d2), .bo(bo2), .busy(busy2), .done(done2)
   );

   // One operation on the 8-bit instance; leaves it back in IDLE.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbi,
                         output int edges, output int busyn, output logic done_after);
      a = ta; b = tb; bi = tbi; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busyn = int'(busy);
      edges = 0;
      while (!done && edges < 40) begin
         @(posedge clk); #1;
         edges++;
         busyn += int'(busy);
      end
      @(posedge clk); #1;
      done_after = done;
   endtask

   task automatic test_reset;
      #2 reset = 1'b1;
      #2;
      tests++;
      if ({d, bo, busy, done} !== 11'd0) begin
         fails++;
         $display("FAIL reset8: got d=%h bo=%b busy=%b done=%b, need all 0", d, bo, busy, done);
      end
      tests++;
      if ({d16, bo16, busy16, done16, d2, bo2, busy2, done2} !== 24'd0) begin
         fails++;
         $display("FAIL reset16_2: got d16=%h bo16=%b d2=%h bo2=%b, need all 0", d16, bo16, d2, bo2);
      end
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      int e, bn; logic da;
      run_op(8'd100, 8'd37, 1'b0, e, bn, da);
      tests++;
      if (e !== 8) begin fails++; $display("FAIL latency: got %0d edges, need 8", e); end
      tests++;
      if (bn !== 8) begin fails++; $display("FAIL busy_len: got %0d cycles, need 8", bn); end
      tests++;
      if (d !== 8'd63 || bo !== 1'b0) begin
         fails++; $display("FAIL basic_100_37: got d=%0d bo=%b, need d=63 bo=0", d, bo);
      end
      tests++;
      if (da !== 1'b0) begin fails++; $display("FAIL done_width: done=%b after DONE, need 0", da); end
   endtask

   task automatic test_borrow;
      int e, bn; logic da;
      logic [7:0] va [3] = '{8'd5, 8'h00, 8'hFF};
      logic [7:0] vb [3] = '{8'd10, 8'h00, 8'hFF};
      logic       vi [3] = '{1'b0, 1'b1, 1'b1};
      logic [8:0] ve [3] = '{9'h1FB, 9'h1FF, 9'h1FF};
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], vi[i], e, bn, da);
         tests++;
         if ({bo, d} !== ve[i]) begin
            fails++;
            $display("FAIL borrow_%0d: got bo=%b d=%h, need bo=%b d=%h", i, bo, d, ve[i][8], ve[i][7:0]);
         end
      end
   endtask

   task automatic test_capture;
      int dones = 0;
      a = 8'h80; b = 8'h01; bi = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      a = 8'h00; b = 8'h00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      tests++;
      if (d !== 8'h7F || bo !== 1'b0) begin
         fails++; $display("FAIL capture: got d=%h bo=%b, need d=7f bo=0", d, bo);
      end
      tests++;
      if (dones !== 1) begin fails++; $display("FAIL ignore_start: got %0d done pulses, need 1", dones); end
   endtask

   task automatic test_back_to_back;
      int hits[$];
      logic dbad = 1'b0;
      a = 8'd3; b = 8'd1; bi = 1'b0; start = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk); #1;
         if (done) begin
            hits.push_back(k);
            if (d !== 8'd2 || bo !== 1'b0) dbad = 1'b1;
         end
      end
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      tests++;
      if (hits.size() !== 3) begin
         fails++; $display("FAIL b2b_count: got %0d done pulses, need 3", hits.size());
      end else begin
         tests++;
         if (hits[0] !== 9 || hits[1] - hits[0] !== 10 || hits[2] - hits[1] !== 10) begin
            fails++; $display("FAIL b2b_spacing: got edges %0d,%0d,%0d, need 9,19,29", hits[0], hits[1], hits[2]);
         end
      end
      tests++;
      if (dbad !== 1'b0) begin fails++; $display("FAIL b2b_value: got wrong d/bo at a done pulse, need d=2 bo=0"); end
   endtask

   task automatic test_abort;
      int dones = 0, e, bn; logic da;
      a = 8'd100; b = 8'd37; bi = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #4 reset = 1'b1;
      #1;
      tests++;
      if ({d, bo, busy, done} !== 11'd0) begin
         fails++; $display("FAIL abort_clear: got d=%h bo=%b busy=%b done=%b, need all 0", d, bo, busy, done);
      end
      #1 reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      tests++;
      if (dones !== 0) begin fails++; $display("FAIL abort_done: got %0d done pulses, need 0", dones); end
      run_op(8'd200, 8'd55, 1'b1, e, bn, da);
      tests++;
      if (d !== 8'd144 || bo !== 1'b0) begin
         fails++; $display("FAIL after_abort: got d=%0d bo=%b, need d=144 bo=0", d, bo);
      end
   endtask

   task automatic test_random;
      int e, bn, bad = 0; logic da;
      logic [7:0] ra, rb; logic ri; logic [8:0] exp;
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         ri = 1'($urandom_range(0, 1));
         exp = {1'b0, ra} - {1'b0, rb} - {8'd0, ri};
         run_op(ra, rb, ri, e, bn, da);
         tests++;
         if ({bo, d} !== exp || e !== 8) begin
            fails++; bad++;
            if (bad <= 5)
               $display("FAIL random_%0d: a=%h b=%h bi=%b got bo=%b d=%h edges=%0d, need bo=%b d=%h edges=8",
                        i, ra, rb, ri, bo, d, e, exp[8], exp[7:0]);
         end
      end
   endtask

   task automatic test_width16;
      logic [15:0] va [2] = '{16'h1234, 16'h0000};
      logic [15:0] vb [2] = '{16'h0235, 16'h0001};
      logic [16:0] ve [2] = '{17'h00FFF, 17'h1FFFF};
      int e;
      for (int i = 0; i < 2; i++) begin
         a16 = va[i]; b16 = vb[i]; bi16 = 1'b0; start16 = 1'b1;
         @(posedge clk); #1;
         start16 = 1'b0; e = 0;
         while (!done16 && e < 40) begin @(posedge clk); #1; e++; end
         tests++;
         if ({bo16, d16} !== ve[i] || e !== 16) begin
            fails++;
            $display("FAIL width16_%0d: got bo=%b d=%h edges=%0d, need bo=%b d=%h edges=16",
                     i, bo16, d16, e, ve[i][16], ve[i][15:0]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_width2;
      logic [1:0] va [2] = '{2'd2, 2'd3};
      logic [1:0] vb [2] = '{2'd3, 2'd1};
      logic       vi [2] = '{1'b0, 1'b1};
      logic [2:0] ve [2] = '{3'b111, 3'b001};
      int e;
      for (int i = 0; i < 2; i++) begin
         a2 = va[i]; b2 = vb[i]; bi2 = vi[i]; start2 = 1'b1;
         @(posedge clk); #1;
         start2 = 1'b0; e = 0;
         while (!done2 && e < 40) begin @(posedge clk); #1; e++; end
         tests++;
         if ({bo2, d2} !== ve[i] || e !== 2) begin
            fails++;
            $display("FAIL width2_%0d: got bo=%b d=%0d edges=%0d, need bo=%b d=%0d edges=2",
                     i, bo2, d2, e, ve[i][2], ve[i][1:0]);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_borrow;
      test_capture;
      test_back_to_back;
      test_abort;
      test_random;
      test_width16;
      test_width2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
